// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the time-multiplexed FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Accumulator width large enough that TAPS full-precision products cannot overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Half-LSB of the output grid, added before the arithmetic shift for round-half-up.
    function automatic logic [63:0] round_const(input int shift);
        return 64'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiplier followed by an accumulator with synchronous clear.
module fir_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 29
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    // The product lands one cycle after en and is folded into the accumulator the cycle after.
    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        if (clr) begin
            acc_d      = '0;
            prod_vld_d = 1'b0;
        end else begin
            if (en) begin
                prod_d     = x * c;
                prod_vld_d = 1'b1;
            end else begin
                prod_d     = prod_q;
                prod_vld_d = 1'b0;
            end
            if (prod_vld_q) begin
                acc_d = acc_q + ACC_W'(prod_q);
            end else begin
                acc_d = acc_q;
            end
        end
    end

    // Pipeline and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_tdm_param.sv
// Time-multiplexed FIR: one MAC, runtime coefficient RAM, valid/ready sample input.
// Define FIR_TDM_SAT_EN to clamp the output and expose sat_flag; otherwise the output wraps.
module fir_tdm_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int TAPS   = 17,
    parameter int OUT_W  = 10,
    parameter int SHIFT  = 14,
    parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    output logic                    busy
`ifdef FIR_TDM_SAT_EN
    ,
    output logic                    sat_flag
`endif
);
    localparam int              AW     = $clog2(TAPS);
    localparam logic [AW-1:0]   K_LAST = AW'(TAPS - 1);
    localparam logic [ACC_W:0]  RND    = (ACC_W + 1)'(round_const(SHIFT));

    fir_state_e               state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic [COEF_W-1:0]        coef_mem [TAPS];

    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic                     fin_q, fin_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     sat_q, sat_d;

    logic                     accept_s;
    logic                     mac_clr_s;
    logic                     mac_en_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [ACC_W:0]    acc_rnd_s;
    logic signed [ACC_W:0]    acc_sh_s;
    logic [OUT_W-1:0]         result_s;
    logic                     sat_s;

    // Host coefficient writes, accepted in any state; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (coef_we && ({1'b0, coef_addr} < (AW + 1)'(TAPS))) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_s),
        .en  (mac_en_s),
        .x   (x_q[k_q]),
        .c   (coef_mem[k_q]),
        .acc (acc_s)
    );

    // Sequencer: accept a sample, step k through every tap, then one cycle to drain the MAC pipe.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        fin_d     = 1'b0;
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        accept_s  = in_valid && in_ready_q;
        case (state_q)
            IDLE: begin
                k_d = '0;
                if (accept_s) begin
                    x_d[0] = in_data;
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    mac_clr_s = 1'b1;
                    state_d   = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == MAC);
    end

    // The last product is folded in while in OUT, so the result is taken one cycle later.
    always_comb begin
        acc_rnd_s = {acc_s[ACC_W-1], acc_s} + RND;
        acc_sh_s  = acc_rnd_s >>> SHIFT;
`ifdef FIR_TDM_SAT_EN
        if ((acc_sh_s[ACC_W:OUT_W-1] == '0) || (acc_sh_s[ACC_W:OUT_W-1] == '1)) begin
            result_s = acc_sh_s[OUT_W-1:0];
            sat_s    = 1'b0;
        end else if (acc_sh_s[ACC_W]) begin
            result_s = {1'b1, {(OUT_W-1){1'b0}}};
            sat_s    = 1'b1;
        end else begin
            result_s = {1'b0, {(OUT_W-1){1'b1}}};
            sat_s    = 1'b1;
        end
`else
        result_s = acc_sh_s[OUT_W-1:0];
        sat_s    = 1'b0;
`endif
        if (fin_q) begin
            out_valid_d = 1'b1;
            out_data_d  = result_s;
            sat_d       = sat_s;
        end else begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            sat_d       = 1'b0;
        end
    end

`ifndef FIR_TDM_SAT_EN
    logic unused_hi_s;
    assign unused_hi_s = ^{acc_sh_s[ACC_W:OUT_W], sat_q};
`endif

    // State, delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '{default: '0};
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef FIR_TDM_SAT_EN
    assign sat_flag  = sat_q;
`endif

endmodule
